// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg
//   Shared types and helpers for clk_period_meter.
//   - meter_state_e : measurement FSM states (SEEK, MEASURE)
//   - LOCK_W        : width of the lock match counter (holds LOCK_CNT up to 15)
//   - DIFF_W        : working width of abs_diff (covers any CNT_W up to 32)
//   - abs_diff()    : unsigned |a - b| without wrap-around
package clk_meter_pkg;

  typedef enum logic {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } meter_state_e;

  localparam int LOCK_W = 4;
  localparam int DIFF_W = 32;

  // Subtract the smaller value from the larger one so the result never
  // wraps, whatever the order of the operands.
  function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                 input logic [DIFF_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// edge_sync
//   Brings the asynchronous slow clock into the i_clk domain through two
//   flops. A third flop keeps the previous synchronised value, so single-cycle
//   edge strobes can be formed from it.
// Ports
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   i_sig      asynchronous input
//   s1         synchronised level (second flop)
//   rise       1 for one cycle after s1 goes 0 -> 1
//   fall       1 for one cycle after s1 goes 1 -> 0
module edge_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_sig,
  output logic s1,
  output logic rise,
  output logic fall
);

  logic s0;
  logic s1_d;

  // NOTE: clocked state always uses non-blocking (<=). With it, every flop
  // samples the value from before the edge, so the chain delays i_sig by one
  // stage per flop. Blocking (=) would let the value ripple through the whole
  // chain in one cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      s1_d <= 1'b0;
    end else begin
      s0   <= i_sig;
      s1   <= s0;
      s1_d <= s1;
    end
  end

  assign rise = s1 & ~s1_d;
  assign fall = ~s1 & s1_d;

endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures the period of a slow clock (i_sig) in i_clk cycles. Optionally
//   it also measures the high time. It reports lock once consecutive periods
//   agree to within TOL cycles.
//   Optional feature macro: CLK_METER_DUTY_EN. When it is defined, the block
//   also measures the high time and reports it on o_high. When it is not
//   defined, o_high is tied to 0.
// Parameters
//   CNT_W     counter width. The all-ones value is the timeout threshold.
//   LOCK_CNT  consecutive matching periods needed for lock (1..15)
//   TOL       largest period-to-period difference that still counts as a match
// Ports
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   i_clr      synchronous clear: return to SEEK and drop lock. o_period is held.
//   i_sig      asynchronous slow clock under measurement
//   o_period   last measured rising-to-rising period
//   o_high     last measured high time (0 when the duty feature is absent)
//   o_valid    1-cycle pulse in the cycle o_period takes a new value
//   o_locked   period stable for LOCK_CNT consecutive matches
//   o_timeout  1-cycle pulse when no rising edge arrives within 2^CNT_W-1 cycles
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clr,
  input  logic             i_sig,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [LOCK_W-1:0] LOCK_TGT = LOCK_W'(LOCK_CNT);

  logic s1;
  logic rise;
  logic fall;

  edge_sync u_edge_sync (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_sig    (i_sig),
    .s1       (s1),
    .rise     (rise),
    .fall     (fall)
  );

  meter_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LOCK_W-1:0] match_q, match_d;
  logic [CNT_W-1:0]  period_d;
  logic              locked_d;
  logic              valid_d;
  logic              timeout_d;
  logic [DIFF_W-1:0] diff;

  // NOTE: every signal written here gets its default first. Then no path
  // through the case can leave a signal unassigned, and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    period_d  = o_period;
    locked_d  = o_locked;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    diff      = abs_diff(DIFF_W'(cnt_q), DIFF_W'(o_period));

    if (i_clr) begin
      // Clear overrides any edge or timeout seen in the same cycle.
      state_d  = SEEK;
      cnt_d    = '0;
      match_d  = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        SEEK: begin
          // The first rise only opens a measurement window. It has no
          // earlier edge to measure from, so no period is reported.
          cnt_d = '0;
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
          end
        end

        MEASURE: begin
          if (rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
            if (diff <= DIFF_W'(TOL)) begin
              match_d  = (match_q >= LOCK_TGT) ? LOCK_TGT : match_q + LOCK_W'(1);
              locked_d = (match_d == LOCK_TGT);
            end else begin
              match_d  = '0;
              locked_d = 1'b0;
            end
          end else if (cnt_q == CNT_MAX) begin
            // No edge within the full counter range: treat the clock as lost.
            timeout_d = 1'b1;
            period_d  = '0;
            locked_d  = 1'b0;
            match_d   = '0;
            cnt_d     = '0;
            state_d   = SEEK;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= SEEK;
      cnt_q     <= '0;
      match_q   <= '0;
      o_period  <= '0;
      o_locked  <= 1'b0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      o_period  <= period_d;
      o_locked  <= locked_d;
      o_valid   <= valid_d;
      o_timeout <= timeout_d;
    end
  end

`ifdef CLK_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt_q;

  // The rise cycle already counts as the first high cycle. So when the fall
  // is seen, hcnt holds the number of i_clk cycles that s1 was high.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hcnt_q <= '0;
      o_high <= '0;
    end else begin
      if (rise) begin
        hcnt_q <= CNT_ONE;
      end else if (s1 && (hcnt_q != CNT_MAX)) begin
        hcnt_q <= hcnt_q + CNT_ONE;
      end

      if (timeout_d) begin
        o_high <= '0;
      end else if (!i_clr && (state_q == MEASURE) && fall) begin
        o_high <= hcnt_q;
      end
    end
  end
`else
  logic unused_duty_inputs;
  assign unused_duty_inputs = s1 | fall;
  assign o_high = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter
//   Directed checks for clk_period_meter (CNT_W=16, LOCK_CNT=4, TOL=1):
//   lock acquisition, tolerance, timeout, synchronous clear, asynchronous reset
//   and high-time measurement. Build with CLK_METER_DUTY_EN defined to exercise
//   the duty path.
module tb_clk_period_meter;

  localparam int CNT_W = 16;

`ifdef CLK_METER_DUTY_EN
  localparam int EXP_H50 = 50;
  localparam int EXP_H30 = 30;
`else
  localparam int EXP_H50 = 0;
  localparam int EXP_H30 = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             sig;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high;
  logic             valid;
  logic             locked;
  logic             timeout;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_valid = 0;
  int last_valid_cyc = 0;
  int nv;
  logic got_to;

  clk_period_meter #(.CNT_W(CNT_W), .LOCK_CNT(4), .TOL(1)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_clr    (clr),
    .i_sig    (sig),
    .o_period (period),
    .o_high   (high),
    .o_valid  (valid),
    .o_locked (locked),
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Drive i_sig for one cycle and sample the outputs 1 time unit after the edge.
  task automatic step(input logic v);
    sig = v;
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
  endtask

  task automatic wave(input int h, input int l);
    repeat (h) step(1'b1);
    repeat (l) step(1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    sig   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_period", period, 0);
    check("rst_high", high, 0);
    check("rst_valid", valid, 0);
    check("rst_locked", locked, 0);
    check("rst_timeout", timeout, 0);
    #2 rst_n = 1'b1;
    repeat (3) step(1'b0);

    // 1: divide-by-100 clock. The first rise only starts the measurement.
    wave(50, 50);
    check("t1_first_rise_no_valid", n_valid, 0);
    for (int k = 2; k <= 6; k++) begin
      wave(50, 50);
      check("t1_valid_count", n_valid, k - 1);
      check("t1_period", period, 100);
      if (k == 5) check("t1_not_locked_4th", locked, 0);
    end
    check("t1_locked_5th", locked, 1);
    check("t1_high", high, EXP_H50);

    // 2: one 102-cycle period breaks lock, one 101-cycle period does not.
    wave(51, 51);
    check("t2_locked_before", locked, 1);
    wave(50, 50);
    check("t2_period_102", period, 102);
    check("t2_unlock_102", locked, 0);
    repeat (4) wave(50, 50);
    check("t2_relock_pending", locked, 0);
    wave(50, 50);
    check("t2_relocked", locked, 1);
    wave(50, 51);
    wave(50, 50);
    check("t2_period_101", period, 101);
    check("t2_stay_locked_101", locked, 1);
    wave(50, 50);
    check("t2_back_100_locked", locked, 1);

    // 3: i_sig stuck low -> timeout 65535 cycles after the last valid.
    got_to = 1'b0;
    for (int i = 0; i < 70000 && !got_to; i++) begin
      step(1'b0);
      if (timeout) got_to = 1'b1;
    end
    check("t3_timeout_seen", got_to, 1);
    check("t3_timeout_delay", cyc - last_valid_cyc, 65535);
    check("t3_period_zero", period, 0);
    check("t3_high_zero", high, 0);
    check("t3_unlocked", locked, 0);
    step(1'b0);
    check("t3_timeout_one_cycle", timeout, 0);
    nv = n_valid;
    wave(50, 50);
    check("t3_no_valid_after_seek", n_valid, nv);
    wave(50, 50);
    check("t3_valid_second_rise", n_valid, nv + 1);
    check("t3_period_after", period, 100);
    repeat (3) wave(50, 50);
    check("t3_relock_pending", locked, 0);
    wave(50, 50);
    check("t3_relocked", locked, 1);

    // 4: i_clr in the cycle the rise reaches the FSM.
    nv = n_valid;
    step(1'b1);
    step(1'b1);
    clr = 1'b1;
    step(1'b1);
    clr = 1'b0;
    check("t4_clr_no_valid", valid, 0);
    check("t4_clr_unlocked", locked, 0);
    check("t4_clr_period_held", period, 100);
    repeat (47) step(1'b1);
    repeat (50) step(1'b0);
    check("t4_no_valid_in_window", n_valid, nv);
    wave(50, 50);
    check("t4_seek_no_valid", n_valid, nv);
    wave(50, 50);
    check("t4_valid_after_seek", n_valid, nv + 1);
    check("t4_period_after", period, 100);
    // o_period was held at 100, so this first period already matches.
    repeat (3) wave(50, 50);
    check("t4_relocked", locked, 1);

    // 5: asynchronous reset in the middle of a period.
    repeat (20) step(1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_period", period, 0);
    check("t5_async_high", high, 0);
    check("t5_async_valid", valid, 0);
    check("t5_async_locked", locked, 0);
    check("t5_async_timeout", timeout, 0);
    repeat (3) step(1'b0);
    #2 rst_n = 1'b1;
    nv = n_valid;
    wave(50, 50);
    check("t5_first_rise_no_valid", n_valid, nv);
    wave(50, 50);
    check("t5_second_rise_valid", n_valid, nv + 1);
    check("t5_period", period, 100);

    // 6: 30% duty cycle.
    wave(30, 70);
    wave(30, 70);
    check("t6_period", period, 100);
    check("t6_high", high, EXP_H30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
